operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Param XLEN, default 32, datapath width of every data port.
REQ-002 Param FWD_N, default 3, forwarding sources; index 0 is the youngest and has the highest priority.
REQ-003 Ports, clock and reset first:
  clk_i  in  1  single clock, all state on rising edge
  rst_n_i  in  1  asynchronous active-low reset
  Flush_i  in  1  synchronous discard of all held entries
  InValid_i  in  1  upstream operand set valid
  InReady_o  out  1  stage accepts this cycle
  ASel_i  in  2  00 reg rs1, 01 PC, 10 zero, 11 zero
  BSel_i  in  2  00 reg rs2, 01 Imm, 10 constant 4, 11 Imm
  StoreEn_i  in  1  instruction needs rs2 as store data
  Rs1Addr_i, Rs2Addr_i  in  5 each  source register numbers
  DataA_i, DataB_i, Pc_i, Imm_i  in  XLEN each  regfile rs1/rs2, PC, immediate
  FwdValid_i  in  FWD_N  source k carries a register write
  FwdPending_i  in  FWD_N  source k result not yet available (load in flight)
  FwdAddr_i  in  5*FWD_N  destination register of source k
  FwdData_i  in  XLEN*FWD_N  result of source k
  OutValid_o  out  1  OpA_o/OpB_o/StoreData_o valid
  OutReady_i  in  1  downstream consumes this cycle
  OpA_o, OpB_o, StoreData_o  out  XLEN each  selected operands, forwarded rs2
  HazardStall_o  out  1  load-use hazard blocks acceptance

Function
REQ-004 Forwarded rs1 = FwdData of the lowest k with FwdValid[k], !FwdPending[k], FwdAddr[k]==Rs1Addr_i, Rs1Addr_i!=0; else DataA_i; rs2 likewise with DataB_i.
REQ-005 Register x0 SHALL never be forwarded nor raise a hazard.
REQ-006 rs1 is needed when ASel_i==00; rs2 is needed when BSel_i==00 or StoreEn_i==1.
REQ-007 HazardStall_o SHALL be 1 when InValid_i and a needed rs matches, at the lowest matching k with FwdValid, a source that has FwdPending set; a younger non-pending match overrides an older pending one.
REQ-008 InReady_o = (state != FULL) && !HazardStall_o; accept = InValid_i && InReady_o.
REQ-009 OpA = forwarded rs1 / Pc_i / 0 per ASel_i; OpB = forwarded rs2 / Imm_i / 4 per BSel_i; StoreData = forwarded rs2 regardless of BSel_i.
REQ-010 Values are captured at the accepting edge; outputs appear registered one cycle later (latency 1, throughput 1 per cycle).
REQ-011 Storage is a main output register plus one skid register; FSM states EMPTY (0 held), BUSY (main held), FULL (main + skid held).
REQ-012 EMPTY: accept -> BUSY with main loaded.
REQ-013 BUSY: accept and OutReady_i -> BUSY, main reloaded; accept only -> FULL, skid loaded; OutReady_i only -> EMPTY; neither -> hold.
REQ-014 FULL: OutReady_i -> BUSY, skid moved to main; else hold; no accept possible.
REQ-015 OutValid_o = (state != EMPTY); outputs SHALL stay stable while OutValid_o && !OutReady_i.
REQ-016 Flush_i SHALL force EMPTY at the next edge, overriding simultaneous accept and consume; InReady_o is unaffected by Flush_i in that cycle but the accepted set is dropped.
REQ-017 Arithmetic: constant 4 zero-extended to XLEN; zero operand is all-zero XLEN.

Reset
REQ-018 rst_n_i low SHALL asynchronously force state EMPTY, OutValid_o 0, and OpA_o, OpB_o, StoreData_o and the skid register to 0, including mid-transfer.
REQ-019 The stage leaves reset on the first rising edge after rst_n_i deasserts; InReady_o is 1 then if no hazard is present.

Verification
REQ-020 Rs1=5, ASel=00, BSel=01, Imm=0x10, Fwd0 valid addr 5 data 0xAAAA, Fwd1 addr 5 data 0xBBBB -> next cycle OpA=0xAAAA, OpB=0x10.
REQ-021 Rs2=7, BSel=00, Fwd0 valid pending addr 7 -> HazardStall_o=1, InReady_o=0, OutValid_o stays 0; pending clears -> accepted, forwarded value appears next cycle.
REQ-022 Rs1=0, Fwd0 valid addr 0 data 0x1234, DataA_i=0 -> OpA=0, no stall.
REQ-023 OutReady_i=0, three back-to-back sets S1..S3 -> S1 held on outputs, S2 in skid, InReady_o=0 while FULL; OutReady_i=1 -> S1, S2, S3 emitted in order, none lost or duplicated.
REQ-024 FULL state, Flush_i=1 with OutReady_i=1 -> next cycle OutValid_o=0, state EMPTY, nothing emitted after.
REQ-025 rst_n_i pulsed low asynchronously while BUSY -> OutValid_o=0 and all operand outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/operand_stage.sv
// Operand stage: resolves rs1/rs2 through the forwarding network, selects
// the A/B/store operands and registers them behind a two-entry skid buffer.
module operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned FWD_N = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    Flush_i,
    input  logic                    InValid_i,
    output logic                    InReady_o,
    input  logic [1:0]              ASel_i,
    input  logic [1:0]              BSel_i,
    input  logic                    StoreEn_i,
    input  logic [4:0]              Rs1Addr_i,
    input  logic [4:0]              Rs2Addr_i,
    input  logic [XLEN-1:0]         DataA_i,
    input  logic [XLEN-1:0]         DataB_i,
    input  logic [XLEN-1:0]         Pc_i,
    input  logic [XLEN-1:0]         Imm_i,
    input  logic [FWD_N-1:0]        FwdValid_i,
    input  logic [FWD_N-1:0]        FwdPending_i,
    input  logic [5*FWD_N-1:0]      FwdAddr_i,
    input  logic [XLEN*FWD_N-1:0]   FwdData_i,
    output logic                    OutValid_o,
    input  logic                    OutReady_i,
    output logic [XLEN-1:0]         OpA_o,
    output logic [XLEN-1:0]         OpB_o,
    output logic [XLEN-1:0]         StoreData_o,
    output logic                    HazardStall_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [XLEN-1:0] fwd_a, fwd_b, sel_a, sel_b;
    logic            pend_a, pend_b, need_a, need_b, accept;
    logic            load_main, load_skid, move_skid;
    logic [XLEN-1:0] main_a, main_b, main_s;
    logic [XLEN-1:0] skid_a, skid_b, skid_s;

    // Forwarding: lowest-index non-pending match supplies the value; the
    // lowest-index valid match alone decides whether the source is still pending.
    always_comb begin
        logic hit_a, hit_b, got_a, got_b;
        fwd_a  = DataA_i;
        fwd_b  = DataB_i;
        pend_a = 1'b0;
        pend_b = 1'b0;
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        got_a  = 1'b0;
        got_b  = 1'b0;
        for (int unsigned k = 0; k < FWD_N; k++) begin
            if (FwdValid_i[k] && (Rs1Addr_i != '0) && (FwdAddr_i[k*5 +: 5] == Rs1Addr_i)) begin
                if (!hit_a) begin
                    hit_a  = 1'b1;
                    pend_a = FwdPending_i[k];
                end
                if (!got_a && !FwdPending_i[k]) begin
                    got_a = 1'b1;
                    fwd_a = FwdData_i[k*XLEN +: XLEN];
                end
            end
            if (FwdValid_i[k] && (Rs2Addr_i != '0) && (FwdAddr_i[k*5 +: 5] == Rs2Addr_i)) begin
                if (!hit_b) begin
                    hit_b  = 1'b1;
                    pend_b = FwdPending_i[k];
                end
                if (!got_b && !FwdPending_i[k]) begin
                    got_b = 1'b1;
                    fwd_b = FwdData_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    assign need_a        = (ASel_i == 2'b00);
    assign need_b        = (BSel_i == 2'b00) || StoreEn_i;
    assign HazardStall_o = InValid_i && ((need_a && pend_a) || (need_b && pend_b));
    assign InReady_o     = (state != FULL) && !HazardStall_o;
    assign accept        = InValid_i && InReady_o;

    // Operand selection from forwarded registers, PC, immediate and constants.
    always_comb begin
        case (ASel_i)
            2'b00:   sel_a = fwd_a;
            2'b01:   sel_a = Pc_i;
            default: sel_a = '0;
        endcase
        case (BSel_i)
            2'b00:   sel_b = fwd_b;
            2'b10:   sel_b = XLEN'(32'd4);
            default: sel_b = Imm_i;
        endcase
    end

    // Skid-buffer control: next state and register load enables.
    always_comb begin
        next_state = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = BUSY;
                    load_main  = 1'b1;
                end
            end
            BUSY: begin
                if (accept && OutReady_i) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (OutReady_i) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (OutReady_i) begin
                    next_state = BUSY;
                    move_skid  = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
        if (Flush_i) begin
            next_state = EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
            move_skid  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= EMPTY;
        else          state <= next_state;
    end

    // Main output and skid data registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_a <= '0;
            main_b <= '0;
            main_s <= '0;
            skid_a <= '0;
            skid_b <= '0;
            skid_s <= '0;
        end else begin
            if (load_main) begin
                main_a <= sel_a;
                main_b <= sel_b;
                main_s <= fwd_b;
            end else if (move_skid) begin
                main_a <= skid_a;
                main_b <= skid_b;
                main_s <= skid_s;
            end
            if (load_skid) begin
                skid_a <= sel_a;
                skid_b <= sel_b;
                skid_s <= fwd_b;
            end
        end
    end

    assign OutValid_o  = (state != EMPTY);
    assign OpA_o       = main_a;
    assign OpB_o       = main_b;
    assign StoreData_o = main_s;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: queue-based reference model plus
// directed vectors with hand-computed expectations.
module tb_operand_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FWD_N = 3;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i = 1'b0;
    logic                  Flush_i, InValid_i, InReady_o, StoreEn_i;
    logic [1:0]            ASel_i, BSel_i;
    logic [4:0]            Rs1Addr_i, Rs2Addr_i;
    logic [XLEN-1:0]       DataA_i, DataB_i, Pc_i, Imm_i;
    logic [FWD_N-1:0]      FwdValid_i, FwdPending_i;
    logic [5*FWD_N-1:0]    FwdAddr_i;
    logic [XLEN*FWD_N-1:0] FwdData_i;
    logic                  OutValid_o, OutReady_i, HazardStall_o;
    logic [XLEN-1:0]       OpA_o, OpB_o, StoreData_o;

    operand_stage #(.XLEN(XLEN), .FWD_N(FWD_N)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .Flush_i(Flush_i),
        .InValid_i(InValid_i), .InReady_o(InReady_o),
        .ASel_i(ASel_i), .BSel_i(BSel_i), .StoreEn_i(StoreEn_i),
        .Rs1Addr_i(Rs1Addr_i), .Rs2Addr_i(Rs2Addr_i),
        .DataA_i(DataA_i), .DataB_i(DataB_i), .Pc_i(Pc_i), .Imm_i(Imm_i),
        .FwdValid_i(FwdValid_i), .FwdPending_i(FwdPending_i),
        .FwdAddr_i(FwdAddr_i), .FwdData_i(FwdData_i),
        .OutValid_o(OutValid_o), .OutReady_i(OutReady_i),
        .OpA_o(OpA_o), .OpB_o(OpB_o), .StoreData_o(StoreData_o),
        .HazardStall_o(HazardStall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } set_t;

    set_t        exp_q[$];
    logic [31:0] emit_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register value as seen by the consumer: youngest ready producer, else regfile.
    function automatic logic [31:0] rs_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        for (int k = 0; k < FWD_N; k++)
            if (FwdValid_i[k] && !FwdPending_i[k] && FwdAddr_i[k*5 +: 5] == r)
                return FwdData_i[k*XLEN +: XLEN];
        return rf;
    endfunction

    // True when the youngest producer of r is still waiting on its result.
    function automatic bit rs_blocked(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        for (int k = 0; k < FWD_N; k++)
            if (FwdValid_i[k] && FwdAddr_i[k*5 +: 5] == r) return FwdPending_i[k];
        return 1'b0;
    endfunction

    function automatic bit model_hazard();
        return InValid_i && (((ASel_i == 2'b00) && rs_blocked(Rs1Addr_i)) ||
                             (((BSel_i == 2'b00) || StoreEn_i) && rs_blocked(Rs2Addr_i)));
    endfunction

    function automatic set_t expected_set();
        set_t e;
        e.a = (ASel_i == 2'b00) ? rs_value(Rs1Addr_i, DataA_i) :
              (ASel_i == 2'b01) ? Pc_i : 32'd0;
        e.b = (BSel_i == 2'b00) ? rs_value(Rs2Addr_i, DataB_i) :
              (BSel_i == 2'b10) ? 32'd4 : Imm_i;
        e.s = rs_value(Rs2Addr_i, DataB_i);
        return e;
    endfunction

    // Reference model: a FIFO of at most two pending operand sets.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exp_q.delete();
        end else begin
            bit acc;
            acc = InValid_i && (exp_q.size() < 2) && !model_hazard();
            if (Flush_i) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && OutReady_i) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(expected_set());
            end
        end
    end

    // Record what the stage actually hands downstream.
    always @(posedge clk_i) begin
        if (rst_n_i && OutValid_o && OutReady_i && !Flush_i) emit_log.push_back(OpA_o);
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk_i) begin
        chk("out_valid", {31'd0, OutValid_o}, {31'd0, exp_q.size() != 0});
        chk("hazard", {31'd0, HazardStall_o}, {31'd0, model_hazard()});
        chk("in_ready", {31'd0, InReady_o}, {31'd0, (exp_q.size() < 2) && !model_hazard()});
        if (exp_q.size() != 0) begin
            chk("op_a", OpA_o, exp_q[0].a);
            chk("op_b", OpB_o, exp_q[0].b);
            chk("store_data", StoreData_o, exp_q[0].s);
        end else if (!rst_n_i) begin
            chk("rst_op_a", OpA_o, 32'd0);
            chk("rst_op_b", OpB_o, 32'd0);
            chk("rst_store", StoreData_o, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        InValid_i    = 1'b0;
        Flush_i      = 1'b0;
        FwdValid_i   = '0;
        FwdPending_i = '0;
        FwdAddr_i    = '0;
        FwdData_i    = '0;
    endtask

    task automatic send(input logic [1:0] asel, input logic [1:0] bsel, input logic st,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] pc, input logic [31:0] imm);
        ASel_i = asel; BSel_i = bsel; StoreEn_i = st;
        Rs1Addr_i = rs1; Rs2Addr_i = rs2;
        DataA_i = da; DataB_i = db; Pc_i = pc; Imm_i = imm;
        InValid_i = 1'b1;
    endtask

    task automatic set_fwd(input int k, input logic v, input logic p,
                           input logic [4:0] a, input logic [31:0] d);
        FwdValid_i[k]             = v;
        FwdPending_i[k]           = p;
        FwdAddr_i[k*5 +: 5]       = a;
        FwdData_i[k*XLEN +: XLEN] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] v;
        int         n;
        idle();
        send(2'b00, 2'b00, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        InValid_i  = 1'b0;
        OutReady_i = 1'b1;
        repeat (3) tick();
        rst_n_i = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, InReady_o}, 32'd1);
        chk("post_rst_out_valid", {31'd0, OutValid_o}, 32'd0);
        chk("post_rst_op_a", OpA_o, 32'd0);

        // Youngest source wins over an older match of the same register.
        send(2'b00, 2'b01, 1'b0, 5'd5, 5'd0, 32'h1111, 32'h2222, 32'h100, 32'h10);
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'hAAAA);
        set_fwd(1, 1'b1, 1'b0, 5'd5, 32'hBBBB);
        tick(); idle();
        chk("prio_op_a", OpA_o, 32'hAAAA);
        chk("prio_op_b", OpB_o, 32'h10);
        chk("prio_valid", {31'd0, OutValid_o}, 32'd1);
        tick();

        // Load-use hazard on rs2, released when the producer completes.
        send(2'b01, 2'b00, 1'b0, 5'd0, 5'd7, 32'd0, 32'h55, 32'h200, 32'd0);
        set_fwd(0, 1'b1, 1'b1, 5'd7, 32'hDEAD);
        #1;
        chk("hz_stall", {31'd0, HazardStall_o}, 32'd1);
        chk("hz_ready", {31'd0, InReady_o}, 32'd0);
        tick(); tick();
        chk("hz_no_out", {31'd0, OutValid_o}, 32'd0);
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h7777);
        #1;
        chk("hz_release_ready", {31'd0, InReady_o}, 32'd1);
        tick(); idle();
        chk("hz_op_a", OpA_o, 32'h200);
        chk("hz_op_b", OpB_o, 32'h7777);
        chk("hz_store", StoreData_o, 32'h7777);
        tick();

        // Younger ready producer hides an older pending one; store data path.
        send(2'b01, 2'b01, 1'b1, 5'd0, 5'd7, 32'd0, 32'h55, 32'h300, 32'h44);
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h1);
        set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h2);
        #1;
        chk("override_stall", {31'd0, HazardStall_o}, 32'd0);
        tick(); idle();
        chk("override_store", StoreData_o, 32'h1);
        chk("override_op_b", OpB_o, 32'h44);
        tick();

        // Pending match on registers the instruction does not need.
        send(2'b01, 2'b01, 1'b0, 5'd9, 5'd9, 32'd0, 32'd0, 32'h400, 32'h8);
        set_fwd(0, 1'b1, 1'b1, 5'd9, 32'h3);
        #1;
        chk("unneeded_stall", {31'd0, HazardStall_o}, 32'd0);
        tick(); idle(); tick();

        // x0 is never forwarded and never stalls.
        send(2'b00, 2'b00, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h500, 32'd0);
        set_fwd(0, 1'b1, 1'b0, 5'd0, 32'h1234);
        set_fwd(1, 1'b1, 1'b1, 5'd0, 32'h9);
        #1;
        chk("x0_stall", {31'd0, HazardStall_o}, 32'd0);
        tick(); idle();
        chk("x0_op_a", OpA_o, 32'd0);
        chk("x0_op_b", OpB_o, 32'd0);
        tick();

        // Constant-four operand and zero A operand.
        send(2'b11, 2'b10, 1'b0, 5'd1, 5'd2, 32'hA1, 32'hB2, 32'hC3, 32'hD4);
        tick(); idle();
        chk("const_op_a", OpA_o, 32'd0);
        chk("const_op_b", OpB_o, 32'd4);
        tick();

        // Streaming every select combination back-to-back.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            send(v[3:2], v[1:0], v[0], 5'd3, 5'd4, 32'hA1 + 32'(i), 32'hB2, 32'hC3, 32'hD4 + 32'(i));
            set_fwd(2, 1'b1, 1'b0, 5'd4, 32'hF00 + 32'(i));
            tick();
        end
        idle(); repeat (2) tick();

        // Backpressure fills main and skid; draining preserves order.
        OutReady_i = 1'b0;
        emit_log.delete();
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h51, 32'h1);
        tick();
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h52, 32'h2);
        tick();
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h53, 32'h3);
        #1;
        chk("full_in_ready", {31'd0, InReady_o}, 32'd0);
        chk("full_op_a", OpA_o, 32'h51);
        tick(); tick();
        chk("full_hold_op_a", OpA_o, 32'h51);
        OutReady_i = 1'b1;
        n = 0;
        while (!InReady_o && n <= 20) begin
            tick();
            n++;
        end
        chk("s3_accept_in_time", {31'd0, n <= 20}, 32'd1);
        tick(); idle();
        repeat (3) tick();
        chk("drain_count", 32'(emit_log.size()), 32'd3);
        if (emit_log.size() == 3) begin
            chk("drain_s1", emit_log[0], 32'h51);
            chk("drain_s2", emit_log[1], 32'h52);
            chk("drain_s3", emit_log[2], 32'h53);
        end

        // Flush from FULL with a simultaneous consume.
        OutReady_i = 1'b0;
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h61, 32'h1);
        tick();
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h62, 32'h2);
        tick();
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h63, 32'h3);
        Flush_i    = 1'b1;
        OutReady_i = 1'b1;
        emit_log.delete();
        tick(); idle();
        chk("flush_full_valid", {31'd0, OutValid_o}, 32'd0);
        repeat (3) tick();
        chk("flush_full_emit", 32'(emit_log.size()), 32'd0);

        // Flush drops a set accepted in the same cycle.
        OutReady_i = 1'b0;
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h71, 32'h1);
        tick();
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h72, 32'h2);
        Flush_i = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, InReady_o}, 32'd1);
        tick(); idle();
        chk("flush_busy_valid", {31'd0, OutValid_o}, 32'd0);
        tick();

        // Asynchronous reset while holding a set.
        send(2'b01, 2'b10, 1'b0, 5'd0, 5'd0, 32'd0, 32'h99, 32'h81, 32'd0);
        tick(); idle();
        chk("pre_rst_valid", {31'd0, OutValid_o}, 32'd1);
        chk("pre_rst_store", StoreData_o, 32'h99);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, OutValid_o}, 32'd0);
        chk("async_rst_op_a", OpA_o, 32'd0);
        chk("async_rst_op_b", OpB_o, 32'd0);
        chk("async_rst_store", StoreData_o, 32'd0);
        tick();
        rst_n_i    = 1'b1;
        OutReady_i = 1'b1;
        send(2'b01, 2'b01, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h91, 32'h92);
        tick(); idle();
        chk("post_async_op_a", OpA_o, 32'h91);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
